// File: rtl/uart_tx_fifo.sv
// Buffered 8-N-1 UART transmitter: FIFO_DEPTH-entry byte FIFO feeding a tick-driven shifter, LSB first.
// o_ready drops while the FIFO is full (pushes then dropped); define UART_TX_PARITY_EN for an even parity bit.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_baud_clock,
  input  logic [7:0] i_data,
  input  logic       i_request,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            baud_prev_q;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            tx_q, tx_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   count_q, count_d;
  logic [7:0]      fifo_mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic            tick;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic [7:0]      head;

  assign tick       = i_baud_clock & ~baud_prev_q;
  assign fifo_empty = (count_q == '0);
  assign o_ready    = (count_q < PW'(FIFO_DEPTH));
  assign push       = i_request & o_ready;
  assign head       = fifo_mem_q[rd_ptr_q[AW-1:0]];
  // A new frame launches from IDLE or at the end of a stop bit, which keeps back-to-back frames gapless.
  assign pop        = tick & ~fifo_empty & ((state_q == S_IDLE) | (state_q == S_STOP));

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end
  end

  // State register; baud_prev keeps tracking during reset so release cannot fake a tick.
  always_ff @(posedge i_clock) begin
    baud_prev_q <= i_baud_clock;
    if (i_reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) state_d = S_START;
        end
        S_START: state_d = S_DATA;
        S_DATA: begin
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: state_d = S_STOP;
`endif
        S_STOP: state_d = fifo_empty ? S_IDLE : S_START;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (tick) begin
      case (state_q)
        S_IDLE, S_STOP: begin
          if (!fifo_empty) begin
            shift_d  = head;
            tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
          end else begin
            tx_d = 1'b1;
          end
        end
        S_START: begin
          tx_d      = shift_q[0];
          bit_cnt_d = 3'd0;
        end
        S_DATA: begin
          if (bit_cnt_q != 3'd7) begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_d = parity_q;
`else
            tx_d = 1'b1;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: tx_d = 1'b1;
`endif
        default: tx_d = 1'b1;
      endcase
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = (state_q != S_IDLE) | (count_q != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame table, directed corner sequences, and a cycle-level queue model under random traffic.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int BITP  = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FW = 11;
`else
  localparam int FW = 10;
`endif

  typedef struct {
    logic [7:0]    dat;
    logic [FW-1:0] frame;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, baud, req, ready, busy, tx;
  logic [7:0] dat;

  always #5 clk = ~clk;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_baud_clock(baud),
    .i_data      (dat),
    .i_request   (req),
    .o_ready     (ready),
    .o_busy      (busy),
    .o_tx        (tx)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic       d_rst, d_req;
  logic [7:0] d_dat;
  bit         baud_force, baud_val;
  int         div_cnt = 0;
  bit         div_out = 1'b0;
  logic       s_tx, s_ready, s_busy;

  // Reference: queue of accepted-but-unsent bytes plus the tick index at which the current frame began.
  logic [7:0] pend[$];
  bit         m_valid = 1'b0;
  logic       m_prev;
  bit         m_active;
  int         tidx, fstart;
  logic [7:0] fbyte;
  logic       m_tx, m_ready, m_busy;
  int         mm_cnt = 0, mm_cyc = 0;
  logic [2:0] mm_act, mm_exp;

  function automatic logic [FW-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  task automatic model_edge(input logic r, input logic q, input logic [7:0] d, input logic b);
    logic          tk;
    int            occ;
    logic [FW-1:0] sh;
    if (r) begin
      pend.delete();
      m_active = 1'b0;
      m_prev   = b;
      tidx     = 0;
      fstart   = 0;
      m_valid  = 1'b1;
    end else begin
      tk     = b & ~m_prev;
      m_prev = b;
      occ    = pend.size();
      if (tk) begin
        tidx++;
        if (!m_active || tidx >= fstart + FW) begin
          if (pend.size() > 0) begin
            fbyte    = pend.pop_front();
            fstart   = tidx;
            m_active = 1'b1;
          end else begin
            m_active = 1'b0;
          end
        end
      end
      if (q && occ < DEPTH) pend.push_back(d);
    end
    sh      = frame_of(fbyte) >> (tidx - fstart);
    m_tx    = m_active ? sh[0] : 1'b1;
    m_ready = (pend.size() < DEPTH);
    m_busy  = m_active || (pend.size() != 0);
  endtask

  // One clock: sample outputs at the falling edge, then drive the next inputs and advance the model.
  task automatic step();
    logic nb;
    @(negedge clk);
    cyc++;
    s_tx    = tx;
    s_ready = ready;
    s_busy  = busy;
    if (m_valid && ({tx, ready, busy} !== {m_tx, m_ready, m_busy})) begin
      if (mm_cnt == 0) begin
        mm_cyc = cyc;
        mm_act = {tx, ready, busy};
        mm_exp = {m_tx, m_ready, m_busy};
      end
      mm_cnt++;
    end
    if (div_cnt == BITP / 2 - 1) begin
      div_cnt = 0;
      div_out = ~div_out;
    end else begin
      div_cnt++;
    end
    nb   = baud_force ? baud_val : div_out;
    rst  = d_rst;
    req  = d_req;
    dat  = d_dat;
    baud = nb;
    model_edge(d_rst, d_req, d_dat, nb);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic check_phase(input string name);
    total++;
    if (mm_cnt == 0) passed++;
    else $display("FAIL %s model: %0d bad cycles, first at cycle %0d tx/ready/busy=%b required %b",
                  name, mm_cnt, mm_cyc, mm_act, mm_exp);
    mm_cnt = 0;
  endtask

  task automatic timeout(input string name);
    total++;
    $display("FAIL %s: timed out at cycle %0d, required event not seen", name, cyc);
  endtask

  task automatic wait_start(output int st, output bit ok);
    ok = 1'b0;
    st = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      step();
      if (s_tx == 1'b0) begin
        ok = 1'b1;
        st = cyc;
      end
    end
    if (!ok) timeout("start_bit");
  endtask

  task automatic recv_frame(output logic [FW-1:0] f, output int st, output bit ok);
    f = '0;
    wait_start(st, ok);
    if (ok) begin
      repeat (5) step();
      f = FW'(s_tx);
      for (int j = 1; j < FW; j++) begin
        repeat (BITP) step();
        f = f | (FW'(s_tx) << j);
      end
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      step();
      if (!s_busy) done = 1'b1;
    end
    if (!done) timeout("wait_idle");
  endtask

  task automatic count_quiet(input int n, output int lows, output int busys);
    lows  = 0;
    busys = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (s_tx !== 1'b1) lows++;
      if (s_busy !== 1'b0) busys++;
    end
  endtask

  vec_t          tbl[6];
  vec_t          ovf[4];
  logic [7:0]    ovf_dat[5];
  logic [FW-1:0] f;
  int            st, n, lows, busys, falls;
  int            st4[4];
  bit            ok;
  logic          prev_tx;

  initial begin
`ifdef UART_TX_PARITY_EN
    tbl[0] = '{8'h55, 11'b1_0_01010101_0};
    tbl[1] = '{8'h07, 11'b1_1_00000111_0};
    tbl[2] = '{8'hA5, 11'b1_0_10100101_0};
    tbl[3] = '{8'h3C, 11'b1_0_00111100_0};
    tbl[4] = '{8'hFF, 11'b1_0_11111111_0};
    tbl[5] = '{8'h80, 11'b1_1_10000000_0};
    ovf[0] = '{8'hA5, 11'b1_0_10100101_0};
    ovf[1] = '{8'h3C, 11'b1_0_00111100_0};
    ovf[2] = '{8'hFF, 11'b1_0_11111111_0};
    ovf[3] = '{8'h00, 11'b1_0_00000000_0};
`else
    tbl[0] = '{8'h55, 10'b1_01010101_0};
    tbl[1] = '{8'h07, 10'b1_00000111_0};
    tbl[2] = '{8'hA5, 10'b1_10100101_0};
    tbl[3] = '{8'h3C, 10'b1_00111100_0};
    tbl[4] = '{8'hFF, 10'b1_11111111_0};
    tbl[5] = '{8'h80, 10'b1_10000000_0};
    ovf[0] = '{8'hA5, 10'b1_10100101_0};
    ovf[1] = '{8'h3C, 10'b1_00111100_0};
    ovf[2] = '{8'hFF, 10'b1_11111111_0};
    ovf[3] = '{8'h00, 10'b1_00000000_0};
`endif
    ovf_dat = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h11};

    d_rst = 1'b1; d_req = 1'b0; d_dat = 8'h00;
    baud_force = 1'b0; baud_val = 1'b0;
    rst = 1'b1; req = 1'b0; dat = 8'h00; baud = 1'b0;

    repeat (3) step();
    d_rst = 1'b0;
    step();
    check("reset_tx", int'(s_tx), 1);
    check("reset_ready", int'(s_ready), 1);
    check("reset_busy", int'(s_busy), 0);

    for (int i = 0; i < 6; i++) begin
      d_req = 1'b1; d_dat = tbl[i].dat;
      step();
      d_req = 1'b0;
      recv_frame(f, st, ok);
      if (ok) check($sformatf("frame_%02h", tbl[i].dat), int'(f), int'(tbl[i].frame));
      if (i == 0) begin
        n = -1;
        for (int k = 0; k < 40 && n < 0; k++) begin
          step();
          if (!s_busy) n = cyc;
        end
        if (n < 0) timeout("busy_fall");
        else check("busy_fall_cycles", n - st, FW * BITP);
      end
      wait_idle();
    end
    check_phase("table");

    baud_force = 1'b1; baud_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_req = 1'b1; d_dat = ovf_dat[i];
      step();
      if (i == 4) check("ovf_ready_after_4th", int'(s_ready), 0);
    end
    d_req = 1'b0;
    step();
    check("ovf_ready_after_5th", int'(s_ready), 0);
    check("ovf_busy_held", int'(s_busy), 1);
    baud_force = 1'b0;
    for (int k = 0; k < 4; k++) begin
      recv_frame(f, st4[k], ok);
      if (ok) check($sformatf("ovf_frame_%0d", k), int'(f), int'(ovf[k].frame));
    end
    for (int k = 1; k < 4; k++) check($sformatf("ovf_gap_%0d", k), st4[k] - st4[k-1], FW * BITP);
    count_quiet(200, lows, busys);
    check("ovf_no_5th_frame", lows, 0);
    check("ovf_busy_after", int'(s_busy), 0);
    check_phase("overflow");

    d_dat = 8'hF0; d_req = 1'b1; step();
    d_dat = 8'h11; step();
    d_dat = 8'h22; step();
    d_req = 1'b0;
    wait_start(st, ok);
    if (ok) begin
      repeat (4 * BITP + 5) step();
      check("rst_premise_bit3", int'(s_tx), 0);
      d_rst = 1'b1; step();
      d_rst = 1'b0; step();
      check("rst_mid_tx", int'(s_tx), 1);
      check("rst_mid_busy", int'(s_busy), 0);
      check("rst_mid_ready", int'(s_ready), 1);
      count_quiet(300, lows, busys);
      check("rst_no_frames_tx", lows, 0);
      check("rst_no_frames_busy", busys, 0);
    end
    check_phase("reset_mid_frame");

    baud_force = 1'b1; baud_val = 1'b0;
    repeat (4) begin
      d_req = 1'b1; d_dat = 8'h00; step();
    end
    d_req = 1'b0;
    step();
    check("full_ready", int'(s_ready), 0);
    baud_val = 1'b1; d_req = 1'b1; d_dat = 8'h00;
    step();
    d_req = 1'b0; baud_force = 1'b0;
    step();
    check("simul_ready", int'(s_ready), 1);
    check("simul_busy", int'(s_busy), 1);
    falls = 0;
    prev_tx = s_tx;
    n = 0;
    for (int k = 0; k < 1500 && n == 0; k++) begin
      step();
      if (prev_tx && !s_tx) falls++;
      prev_tx = s_tx;
      if (!s_busy) n = 1;
    end
    if (n == 0) timeout("simul_drain");
    else check("simul_frames", falls, 3);
    check_phase("simul_push_pop");

    count_quiet(1000, lows, busys);
    check("idle_tx_high", lows, 0);
    check("idle_not_busy", busys, 0);
    check_phase("idle");

    for (int k = 0; k < 4000; k++) begin
      d_req = ($urandom_range(0, 7) == 0);
      d_dat = 8'($urandom);
      d_rst = ($urandom_range(0, 1499) == 0);
      step();
    end
    d_req = 1'b0; d_rst = 1'b0;
    wait_idle();
    check_phase("random");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
